// File: rtl/ai_act_pkg.sv
// ============================================================================
// Module      : ai_act_pkg
// Description : Shared activation/data-type codes, arbiter FSM states and
//               per-type enable-hold latency helper.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ai_act_pkg;

    localparam logic [2:0] ACT_RELU    = 3'b100;
    localparam logic [2:0] ACT_SIGMOID = 3'b101;
    localparam logic [2:0] ACT_TANH    = 3'b110;

    localparam logic [2:0] DT_FP32  = 3'b101;
    localparam logic [2:0] DT_INT32 = 3'b010;

    localparam int LAT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_e;

    // Sigmoid/Tanh use the deep pipe; everything else (incl. pass-through) is short.
    function automatic logic [LAT_W-1:0] lat_for_type(input logic [2:0] act_type,
                                                      input int        relu_lat,
                                                      input int        cplx_lat);
        if (act_type == ACT_SIGMOID || act_type == ACT_TANH)
            return LAT_W'(cplx_lat);
        return LAT_W'(relu_lat);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ai_rr_arbiter.sv
// ============================================================================
// Module      : ai_rr_arbiter
// Description : Combinational round-robin pick: first request at/after the
//               pointer, wrapping; one-hot grant plus encoded index.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ai_rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW:0] w_k;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_k     = '0;
        for (int i = 0; i < N; i++) begin
            w_k = {1'b0, i_ptr} + (IW+1)'(i);
            if (w_k >= (IW+1)'(N))
                w_k = w_k - (IW+1)'(N);
            if (!o_any && i_req[w_k[IW-1:0]]) begin
                o_any                 = 1'b1;
                o_idx                 = w_k[IW-1:0];
                o_grant[w_k[IW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ai_activation_arbiter.sv
// ============================================================================
// Module      : ai_activation_arbiter
// Description : Round-robin sharing of one activation unit between NUM_REQ
//               requesters, one op in flight, tagged valid/ready response.
//               Optional ACT_ARB_PERF_CNT_EN adds grant/busy perf counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ai_activation_arbiter
    import ai_act_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int XLEN     = 64,
    parameter  int RELU_LAT = 1,
    parameter  int CPLX_LAT = 4,
    localparam int IDW      = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*3-1:0]    req_type,
    input  logic [NUM_REQ*3-1:0]    req_dtype,
    input  logic [NUM_REQ*XLEN-1:0] req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [XLEN-1:0]         rsp_data,
    output logic                    rsp_ovf,
    output logic                    rsp_unf,
    output logic                    act_enable,
    output logic [2:0]              act_type,
    output logic [2:0]              act_dtype,
    output logic [XLEN-1:0]         act_data,
    input  logic [XLEN-1:0]         act_result,
    input  logic                    act_valid,
    input  logic                    act_overflow,
    input  logic                    act_underflow,
    output logic                    busy,
    output logic                    proto_err
`ifdef ACT_ARB_PERF_CNT_EN
    ,
    output logic [NUM_REQ*32-1:0]   perf_grants,
    output logic [31:0]             perf_busy
`endif
);

    arb_state_e        r_state;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    r_id;
    logic [LAT_W-1:0]  r_cnt;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDW-1:0]     w_idx;
    logic               w_any;
    logic [2:0]         w_sel_type;
    logic [2:0]         w_sel_dtype;
    logic [XLEN-1:0]    w_sel_data;
    logic               w_idle;

    assign w_idle    = (r_state == ST_IDLE);
    assign busy      = !w_idle;
    assign req_ready = (w_idle && !rst) ? w_grant : '0;

    ai_rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel_type  = '0;
        w_sel_dtype = '0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_type  = req_type[i*3 +: 3];
                w_sel_dtype = req_dtype[i*3 +: 3];
                w_sel_data  = req_data[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_id       <= '0;
            r_cnt      <= '0;
            act_enable <= 1'b0;
            act_type   <= '0;
            act_dtype  <= '0;
            act_data   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_ovf    <= 1'b0;
            rsp_unf    <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_id       <= w_idx;
                        act_type   <= w_sel_type;
                        act_dtype  <= w_sel_dtype;
                        act_data   <= w_sel_data;
                        act_enable <= 1'b1;
                        r_cnt      <= lat_for_type(w_sel_type, RELU_LAT, CPLX_LAT);
                        r_ptr      <= (w_idx == IDW'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Enable is held for exactly the loaded count of cycles.
                    if (r_cnt <= LAT_W'(1)) begin
                        act_enable <= 1'b0;
                        r_state    <= ST_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    rsp_data  <= act_result;
                    rsp_ovf   <= act_overflow;
                    rsp_unf   <= act_underflow;
                    rsp_id    <= r_id;
                    rsp_valid <= 1'b1;
                    if (!act_valid)
                        proto_err <= 1'b1;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ACT_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grants <= '0;
            perf_busy   <= '0;
        end else begin
            if (busy)
                perf_busy <= perf_busy + 32'd1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i])
                    perf_grants[i*32 +: 32] <= perf_grants[i*32 +: 32] + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
